onehot_monitor: RTL and testbench
=================================

ONEHOT_MONITOR -- requirements
Module: onehot_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independently checked channels (>=1).
REQ-002 SHALL have parameter WIDTH, default 64: bits per channel vector (>=2).
REQ-003 SHALL have parameter ALLOW_ZERO, default 0: nonzero means all-zero is legal.
REQ-004 SHALL have parameter ZERO_TIMEOUT, default 0: max consecutive all-zero enabled cycles when ALLOW_ZERO!=0; 0 disables the check.
REQ-005 SHALL have parameter CNT_W, default 16: violation counter width.
REQ-006 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port en, input, NUM_CH: per-channel check enable.
REQ-009 SHALL have port expr, input, NUM_CH*WIDTH: channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 SHALL have port clr, input, 1: single-cycle pulse clearing sticky state.
REQ-011 SHALL have port err_pulse, output, NUM_CH: one-cycle flag per channel violation.
REQ-012 SHALL have port err_sticky, output, NUM_CH: per-channel latched error.
REQ-013 SHALL have port viol_cnt, output, CNT_W: total violation count, saturating.
REQ-014 SHALL have port first_valid, output, 1: first-failure record valid.
REQ-015 SHALL have ports first_ch (clog2(NUM_CH), min 1), first_type (2), first_val (WIDTH), all outputs: channel, type and vector of the first failure.
REQ-016 SHALL have port irq, output, 1: OR of err_sticky.

Function
REQ-017 Channel c SHALL be checked only in cycles with en[c]=1; en[c]=0 SHALL produce no violation and SHALL reset that channel's zero-run counter.
REQ-018 Violation types SHALL be MULTI (popcount>=2), ZERO (all-zero while ALLOW_ZERO=0), TIMEOUT (zero-run reaches ZERO_TIMEOUT).
REQ-019 Per channel, type priority SHALL be MULTI > ZERO > TIMEOUT.
REQ-020 Zero-run counter SHALL increment on each enabled all-zero cycle, clear on any nonzero enabled cycle, saturate at ZERO_TIMEOUT, and flag TIMEOUT only in the cycle it reaches ZERO_TIMEOUT.
REQ-021 err_pulse[c] SHALL assert exactly one cycle after the violating input cycle (latency 1).
REQ-022 err_sticky[c] SHALL set with err_pulse[c] and hold until clr or reset.
REQ-023 viol_cnt SHALL add the number of channels violating per cycle (0..NUM_CH), saturating at 2^CNT_W-1 with no wrap.
REQ-024 First-capture FSM SHALL have states IDLE and CAPTURED; IDLE->CAPTURED on the first violation cycle; CAPTURED holds until clr.
REQ-025 On simultaneous channel violations, capture SHALL record the lowest-index channel.
REQ-026 first_* SHALL update in the same cycle as err_pulse; first_val SHALL be the offending vector.
REQ-027 clr SHALL zero err_sticky, viol_cnt and first_valid and return the FSM to IDLE next cycle.
REQ-028 A violation coincident with clr SHALL take effect after the clear: sticky set, viol_cnt equals that cycle's count, and the violation is captured.
REQ-029 irq SHALL be registered and equal the OR of err_sticky.

Reset
REQ-030 On rst_n low, all outputs and zero-run counters SHALL go to 0 and the FSM to IDLE asynchronously; first_type SHALL reset to MULTI encoding 0.
REQ-031 An in-progress zero run SHALL be discarded by reset; counting restarts after deassertion.

Structure
REQ-032 Package onehot_mon_pkg SHALL hold viol_type_e (MULTI=0, ZERO=1, TIMEOUT=2) and mon_state_e (IDLE, CAPTURED).
REQ-033 Per-channel check logic and the zero-run counter SHALL live in sub-module onehot_mon_ch, instantiated NUM_CH times.
REQ-034 The top SHALL hold counter, sticky, capture FSM and irq.

Verification (NUM_CH=4, WIDTH=8)
REQ-035 ch2 en=1, expr=8'h05 -> next cycle err_pulse=4'b0100, first_ch=2, type MULTI, first_val=8'h05, viol_cnt=1, irq=1.
REQ-036 ALLOW_ZERO=0, ch0 en=1, expr=0; ch1 en=0, expr=8'hFF -> only ch0 ZERO flagged; ch1 ignored.
REQ-037 ALLOW_ZERO=1, ZERO_TIMEOUT=3, ch3 zero for 5 enabled cycles -> single err_pulse[3] after 3rd cycle, type TIMEOUT.
REQ-038 ch1 and ch3 violate in the same cycle -> viol_cnt+=2, first_ch=1; a later ch0 violation leaves first_ch=1.
REQ-039 CNT_W=2, 5 violations -> viol_cnt=3; clr coincident with a ch0 violation -> viol_cnt=1, first_ch=0, first_valid=1.
REQ-040 rst_n asserted mid zero-run and with sticky set -> all outputs 0 immediately; zero run restarts from 0 after release.

Source files
------------

// File: rtl/onehot_mon_pkg.sv
// rtl/onehot_mon_pkg.sv - shared types and helpers for the one-hot monitor
package onehot_mon_pkg;

  typedef enum logic [1:0] {
    MULTI   = 2'd0,
    ZERO    = 2'd1,
    TIMEOUT = 2'd2
  } viol_type_e;

  typedef enum logic {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } mon_state_e;

  // Bits needed to index n items, never less than one so ports stay legal.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/onehot_mon_ch.sv
// rtl/onehot_mon_ch.sv - single-channel one-hot check with zero-run tracking
module onehot_mon_ch
  import onehot_mon_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int ALLOW_ZERO   = 0,
  parameter int ZERO_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] vec,
  output logic             viol,
  output viol_type_e       vtype
);

  localparam int               RUN_W      = min1_clog2(ZERO_TIMEOUT + 1);
  localparam bit               ZERO_LEGAL = (ALLOW_ZERO != 0);
  localparam bit               RUN_CHECK  = ZERO_LEGAL && (ZERO_TIMEOUT > 0);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(ZERO_TIMEOUT);

  logic             is_zero;
  logic             is_multi;
  logic             run_hit;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [RUN_W-1:0] run_inc;

  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign is_zero  = (vec == '0);
  assign is_multi = ((vec & (vec - WIDTH'(1))) != '0);
  assign run_inc  = run_q + RUN_W'(1);

  // Zero-run length: counts enabled all-zero cycles, holds at the limit, flags only on arrival
  always_comb begin
    run_d   = run_q;
    run_hit = 1'b0;
    if (!RUN_CHECK || !en || !is_zero) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d   = run_inc;
      run_hit = (run_inc == RUN_MAX);
    end
  end

  // Zero-run register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // Violation classification with MULTI over ZERO over TIMEOUT
  always_comb begin
    viol  = 1'b0;
    vtype = MULTI;
    if (en) begin
      if (is_multi) begin
        viol  = 1'b1;
        vtype = MULTI;
      end else if (is_zero && !ZERO_LEGAL) begin
        viol  = 1'b1;
        vtype = ZERO;
      end else if (run_hit) begin
        viol  = 1'b1;
        vtype = TIMEOUT;
      end
    end
  end

endmodule

// File: rtl/onehot_monitor.sv
// rtl/onehot_monitor.sv - multi-channel one-hot monitor with counters and first-failure capture
module onehot_monitor
  import onehot_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 64,
  parameter int ALLOW_ZERO   = 0,
  parameter int ZERO_TIMEOUT = 0,
  parameter int CNT_W        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               en,
  input  logic [NUM_CH*WIDTH-1:0]         expr,
  input  logic                            clr,
  output logic [NUM_CH-1:0]               err_pulse,
  output logic [NUM_CH-1:0]               err_sticky,
  output logic [CNT_W-1:0]                viol_cnt,
  output logic                            first_valid,
  output logic [min1_clog2(NUM_CH)-1:0]   first_ch,
  output logic [1:0]                      first_type,
  output logic [WIDTH-1:0]                first_val,
  output logic                            irq
);

  localparam int               CH_W    = min1_clog2(NUM_CH);
  localparam int               SUM_W   = $clog2(NUM_CH + 1);
  localparam int               ACC_W   = CNT_W + SUM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0] viol;
  viol_type_e        vtype [NUM_CH];
  logic              any_viol;
  logic [SUM_W-1:0]  viol_sum;

  logic [CH_W-1:0]   pick_ch;
  viol_type_e        pick_type;
  logic [WIDTH-1:0]  pick_val;

  logic [NUM_CH-1:0] pulse_q;
  logic [NUM_CH-1:0] sticky_q;
  logic [NUM_CH-1:0] sticky_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [ACC_W-1:0]  cnt_sum;
  logic              irq_q;

  mon_state_e        state_q;
  mon_state_e        state_d;
  logic              capture;
  logic [CH_W-1:0]   fch_q;
  viol_type_e        ftype_q;
  logic [WIDTH-1:0]  fval_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    onehot_mon_ch #(
      .WIDTH        (WIDTH),
      .ALLOW_ZERO   (ALLOW_ZERO),
      .ZERO_TIMEOUT (ZERO_TIMEOUT)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en[c]),
      .vec   (expr[c*WIDTH +: WIDTH]),
      .viol  (viol[c]),
      .vtype (vtype[c])
    );
  end

  assign any_viol = |viol;

  // Number of channels violating this cycle
  always_comb begin
    viol_sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      viol_sum = viol_sum + SUM_W'(viol[c]);
    end
  end

  // Lowest-index violating channel wins; scan downward so the last hit is the lowest
  always_comb begin
    pick_ch   = '0;
    pick_type = MULTI;
    pick_val  = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (viol[c]) begin
        pick_ch   = CH_W'(c);
        pick_type = vtype[c];
        pick_val  = expr[c*WIDTH +: WIDTH];
      end
    end
  end

  // Saturating total; clr drops the old value but this cycle's violations still count
  always_comb begin
    cnt_sum  = (clr ? {ACC_W{1'b0}} : ACC_W'(cnt_q)) + ACC_W'(viol_sum);
    cnt_d    = (cnt_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    sticky_d = (clr ? {NUM_CH{1'b0}} : sticky_q) | viol;
  end

  // Pulse, sticky, counter and interrupt registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      pulse_q  <= viol;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      irq_q    <= |sticky_d;
    end
  end

  // Capture state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture next state: a violation arms it, clr alone returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (any_viol) state_d = CAPTURED;
      CAPTURED: if (clr)      state_d = any_viol ? CAPTURED : IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Capture outputs: record in IDLE, or when clr reopens the window in the same cycle
  always_comb begin
    capture     = any_viol && ((state_q == IDLE) || clr);
    first_valid = (state_q == CAPTURED);
  end

  // First-failure record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fch_q   <= '0;
      ftype_q <= MULTI;
      fval_q  <= '0;
    end else if (capture) begin
      fch_q   <= pick_ch;
      ftype_q <= pick_type;
      fval_q  <= pick_val;
    end else if (clr) begin
      fch_q   <= '0;
      ftype_q <= MULTI;
      fval_q  <= '0;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign viol_cnt   = cnt_q;
  assign first_ch   = fch_q;
  assign first_type = ftype_q;
  assign first_val  = fval_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_onehot_monitor.sv
// tb/tb_onehot_monitor.sv - self-checking bench for onehot_monitor
module tb_onehot_monitor;

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] expr;
    logic        clr;
    logic [3:0]  pulse;
    logic [3:0]  sticky;
    logic [15:0] cnt;
    logic        fv;
    logic [1:0]  fch;
    logic [1:0]  ftype;
    logic [7:0]  fval;
    logic        irq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT A: zero illegal, wide counter
  logic [3:0]  en_a = '0;
  logic [31:0] expr_a = '0;
  logic        clr_a = 1'b0;
  logic [3:0]  pulse_a, sticky_a;
  logic [15:0] cnt_a;
  logic        fv_a, irq_a;
  logic [1:0]  fch_a, ftype_a;
  logic [7:0]  fval_a;

  // DUT B: zero legal, timeout 3
  logic [3:0]  en_b = '0;
  logic [31:0] expr_b = '0;
  logic        clr_b = 1'b0;
  logic [3:0]  pulse_b, sticky_b;
  logic [15:0] cnt_b;
  logic        fv_b, irq_b;
  logic [1:0]  fch_b, ftype_b;
  logic [7:0]  fval_b;

  // DUT C: zero illegal, 2-bit counter
  logic [3:0]  en_c = '0;
  logic [31:0] expr_c = '0;
  logic        clr_c = 1'b0;
  logic [3:0]  pulse_c, sticky_c;
  logic [1:0]  cnt_c;
  logic        fv_c, irq_c;
  logic [1:0]  fch_c, ftype_c;
  logic [7:0]  fval_c;

  onehot_monitor #(.NUM_CH(4), .WIDTH(8), .ALLOW_ZERO(0), .ZERO_TIMEOUT(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .expr(expr_a), .clr(clr_a),
    .err_pulse(pulse_a), .err_sticky(sticky_a), .viol_cnt(cnt_a), .first_valid(fv_a),
    .first_ch(fch_a), .first_type(ftype_a), .first_val(fval_a), .irq(irq_a)
  );

  onehot_monitor #(.NUM_CH(4), .WIDTH(8), .ALLOW_ZERO(1), .ZERO_TIMEOUT(3), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .expr(expr_b), .clr(clr_b),
    .err_pulse(pulse_b), .err_sticky(sticky_b), .viol_cnt(cnt_b), .first_valid(fv_b),
    .first_ch(fch_b), .first_type(ftype_b), .first_val(fval_b), .irq(irq_b)
  );

  onehot_monitor #(.NUM_CH(4), .WIDTH(8), .ALLOW_ZERO(0), .ZERO_TIMEOUT(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .expr(expr_c), .clr(clr_c),
    .err_pulse(pulse_c), .err_sticky(sticky_c), .viol_cnt(cnt_c), .first_valid(fv_c),
    .first_ch(fch_c), .first_type(ftype_c), .first_val(fval_c), .irq(irq_c)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic [31:0] expr, input logic clr,
                              input logic [3:0] pulse, input logic [3:0] sticky, input logic [15:0] cnt,
                              input logic fv, input logic [1:0] fch, input logic [1:0] ftype,
                              input logic [7:0] fval, input logic irq);
    vec_t v;
    v.en = en; v.expr = expr; v.clr = clr; v.pulse = pulse; v.sticky = sticky; v.cnt = cnt;
    v.fv = fv; v.fch = fch; v.ftype = ftype; v.fval = fval; v.irq = irq;
    return v;
  endfunction

  vec_t tab [12];

  initial begin
    //             en     expr {ch3,ch2,ch1,ch0}     clr  pulse  sticky  cnt fv fch ftype fval   irq
    tab[0]  = mk(4'h0, 32'h00000000, 1'b0, 4'h0, 4'h0, 16'd0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tab[1]  = mk(4'hF, 32'h80100201, 1'b0, 4'h0, 4'h0, 16'd0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tab[2]  = mk(4'h4, 32'h00050000, 1'b0, 4'h4, 4'h4, 16'd1, 1'b1, 2'd2, 2'd0, 8'h05, 1'b1);
    tab[3]  = mk(4'h1, 32'h0000FF00, 1'b0, 4'h1, 4'h5, 16'd2, 1'b1, 2'd2, 2'd0, 8'h05, 1'b1);
    tab[4]  = mk(4'h0, 32'h00000000, 1'b1, 4'h0, 4'h0, 16'd0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tab[5]  = mk(4'h1, 32'h00000000, 1'b0, 4'h1, 4'h1, 16'd1, 1'b1, 2'd0, 2'd1, 8'h00, 1'b1);
    tab[6]  = mk(4'h0, 32'h00000000, 1'b1, 4'h0, 4'h0, 16'd0, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0);
    tab[7]  = mk(4'hF, 32'h00400301, 1'b0, 4'hA, 4'hA, 16'd2, 1'b1, 2'd1, 2'd0, 8'h03, 1'b1);
    tab[8]  = mk(4'h1, 32'h000000FF, 1'b0, 4'h1, 4'hB, 16'd3, 1'b1, 2'd1, 2'd0, 8'h03, 1'b1);
    tab[9]  = mk(4'hF, 32'h00000000, 1'b0, 4'hF, 4'hF, 16'd7, 1'b1, 2'd1, 2'd0, 8'h03, 1'b1);
    tab[10] = mk(4'h4, 32'h00000000, 1'b1, 4'h4, 4'h4, 16'd1, 1'b1, 2'd2, 2'd1, 8'h00, 1'b1);
    tab[11] = mk(4'h0, 32'h00000000, 1'b0, 4'h0, 4'h4, 16'd1, 1'b1, 2'd2, 2'd1, 8'h00, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset pulse_a", 64'(pulse_a), 64'h0);
    chk("reset cnt_a", 64'(cnt_a), 64'h0);
    chk("reset fv_a", 64'(fv_a), 64'h0);
    chk("reset ftype_a", 64'(ftype_a), 64'h0);
    chk("reset irq_a", 64'(irq_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table vectors on DUT A: apply, clock once, compare registered results
    for (int i = 0; i < 12; i++) begin
      en_a = tab[i].en; expr_a = tab[i].expr; clr_a = tab[i].clr;
      step();
      chk($sformatf("row%0d pulse", i), 64'(pulse_a), 64'(tab[i].pulse));
      chk($sformatf("row%0d sticky", i), 64'(sticky_a), 64'(tab[i].sticky));
      chk($sformatf("row%0d cnt", i), 64'(cnt_a), 64'(tab[i].cnt));
      chk($sformatf("row%0d first_valid", i), 64'(fv_a), 64'(tab[i].fv));
      chk($sformatf("row%0d irq", i), 64'(irq_a), 64'(tab[i].irq));
      if (tab[i].fv) begin
        chk($sformatf("row%0d first_ch", i), 64'(fch_a), 64'(tab[i].fch));
        chk($sformatf("row%0d first_type", i), 64'(ftype_a), 64'(tab[i].ftype));
        chk($sformatf("row%0d first_val", i), 64'(fval_a), 64'(tab[i].fval));
      end
    end
    en_a = '0; expr_a = '0; clr_a = 1'b0;

    // DUT C: five ch1 ZERO violations saturate a 2-bit counter
    en_c = 4'b0010; expr_c = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("sat cnt k%0d", k), 64'(cnt_c), 64'((k < 3) ? k + 1 : 3));
      chk($sformatf("sat pulse k%0d", k), 64'(pulse_c), 64'h2);
    end
    chk("sat first_ch", 64'(fch_c), 64'd1);
    // clr coincident with a ch0 violation
    clr_c = 1'b1; en_c = 4'b0001;
    step();
    clr_c = 1'b0; en_c = 4'b0000;
    chk("clrviol cnt", 64'(cnt_c), 64'd1);
    chk("clrviol first_ch", 64'(fch_c), 64'd0);
    chk("clrviol first_valid", 64'(fv_c), 64'd1);
    chk("clrviol first_type", 64'(ftype_c), 64'd1);
    chk("clrviol sticky", 64'(sticky_c), 64'h1);
    step();
    chk("clrviol hold cnt", 64'(cnt_c), 64'd1);

    // DUT B: ch3 zero for five enabled cycles, single TIMEOUT after the third
    en_b = 4'b1000; expr_b = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("to pulse k%0d", k), 64'(pulse_b), 64'((k == 2) ? 4'h8 : 4'h0));
      if (k == 2) begin
        chk("to first_valid", 64'(fv_b), 64'd1);
        chk("to first_ch", 64'(fch_b), 64'd3);
        chk("to first_type", 64'(ftype_b), 64'd2);
        chk("to first_val", 64'(fval_b), 64'h0);
        chk("to irq", 64'(irq_b), 64'd1);
      end
    end
    chk("to cnt", 64'(cnt_b), 64'd1);
    // Nonzero clears the run; disable also clears it
    expr_b = 32'h20000000;
    step(); chk("run nz", 64'(pulse_b), 64'h0);
    expr_b = 32'h0;
    step(); chk("run z1", 64'(pulse_b), 64'h0);
    step(); chk("run z2", 64'(pulse_b), 64'h0);
    en_b = 4'b0000;
    step(); chk("run dis", 64'(pulse_b), 64'h0);
    en_b = 4'b1000;
    step(); chk("run e1", 64'(pulse_b), 64'h0);
    step(); chk("run e2", 64'(pulse_b), 64'h0);
    step(); chk("run e3", 64'(pulse_b), 64'h8);
    chk("run cnt", 64'(cnt_b), 64'd2);
    chk("run first_ch", 64'(fch_b), 64'd3);

    // Reset mid zero-run with sticky set
    expr_b = 32'h01000000;
    step();
    expr_b = 32'h0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst pulse", 64'(pulse_b), 64'h0);
    chk("arst sticky", 64'(sticky_b), 64'h0);
    chk("arst cnt", 64'(cnt_b), 64'h0);
    chk("arst first_valid", 64'(fv_b), 64'h0);
    chk("arst first_ch", 64'(fch_b), 64'h0);
    chk("arst first_type", 64'(ftype_b), 64'h0);
    chk("arst irq", 64'(irq_b), 64'h0);
    chk("arst sticky_a", 64'(sticky_a), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk("rerun z1", 64'(pulse_b), 64'h0);
    step(); chk("rerun z2", 64'(pulse_b), 64'h0);
    step(); chk("rerun z3", 64'(pulse_b), 64'h8);
    en_b = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
